// File: rtl/cpu_ctrl.sv
// Multi-cycle sequencing controller for the 16-bit accumulator/stack datapath.
// Holds the instruction register, decodes it into per-cycle datapath strobes, counts retirements.
module cpu_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        ivalid,
  input  logic        go,
  output logic [15:0] isr,
  output logic        regw,
  output logic        memw,
  output logic [1:0]  memin,
  output logic        sflag,
  output logic [1:0]  spi,
  output logic        spld,
  output logic        pcin,
  output logic        pci,
  output logic        pcld,
  output logic        halted,
  output logic [15:0] icount
);

  localparam logic [2:0] StFetch = 3'd0;
  localparam logic [2:0] StExec  = 3'd1;
  localparam logic [2:0] StCall2 = 3'd2;
  localparam logic [2:0] StRet2  = 3'd3;
  localparam logic [2:0] StRet3  = 3'd4;
  localparam logic [2:0] StHalt  = 3'd5;

  localparam logic [1:0] SpHold = 2'd0;
  localparam logic [1:0] SpInc  = 2'd1;
  localparam logic [1:0] SpDec  = 2'd2;

  logic [2:0]  state_q, state_d;
  logic [15:0] isr_q, isr_d;
  logic [15:0] icount_q, icount_d;
  logic        retire;

  logic [3:0] op;
  logic       is_br, is_push, is_call, is_misc, is_ret, is_halt;

  assign op      = isr_q[15:12];
  // Ops 0000-1000 are all branches; the datapath evaluates the condition itself.
  assign is_br   = ~op[3] | (op == 4'b1000);
  assign is_push = (op == 4'b1001);
  assign is_call = (op == 4'b1010);
  assign is_misc = (op == 4'b1011);
  assign is_ret  = is_misc & (isr_q[1:0] == 2'b00);
  assign is_halt = is_misc & (isr_q[1:0] == 2'b10);

  always_comb begin
    state_d = state_q;
    isr_d   = isr_q;
    retire  = 1'b0;
    regw    = 1'b0;
    memw    = 1'b0;
    memin   = 2'd0;
    sflag   = 1'b0;
    spi     = SpHold;
    spld    = 1'b0;
    pcin    = 1'b0;
    pci     = 1'b0;
    pcld    = 1'b0;

    unique case (state_q)
      StFetch: begin
        if (ivalid) begin
          isr_d   = instr;
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = StFetch;
        if (is_br) begin
          pcin   = 1'b1;
          pci    = 1'b1;
          pcld   = 1'b1;
          retire = 1'b1;
        end else if (is_push) begin
          memw   = 1'b1;
          memin  = 2'd0;
          spi    = SpDec;
          spld   = 1'b1;
          pcin   = 1'b1;
          pcld   = 1'b1;
          retire = 1'b1;
        end else if (is_call) begin
          // Push the return address; the PC moves in CALL2.
          memw    = 1'b1;
          memin   = 2'd1;
          spi     = SpDec;
          spld    = 1'b1;
          state_d = StCall2;
        end else if (is_ret) begin
          spi     = SpInc;
          spld    = 1'b1;
          state_d = StRet2;
        end else if (is_misc) begin
          // HALT and NOP both advance the PC before finishing.
          pcin   = 1'b1;
          pcld   = 1'b1;
          retire = 1'b1;
          if (is_halt) state_d = StHalt;
        end else begin
          regw   = 1'b1;
          sflag  = 1'b1;
          pcin   = 1'b1;
          pcld   = 1'b1;
          retire = 1'b1;
        end
      end
      StCall2: begin
        pcin    = 1'b1;
        pci     = 1'b1;
        pcld    = 1'b1;
        retire  = 1'b1;
        state_d = StFetch;
      end
      StRet2: begin
        pcld    = 1'b1;
        state_d = StRet3;
      end
      StRet3: begin
        // Stacked value is the CALL's own address; step past it.
        pcin    = 1'b1;
        pcld    = 1'b1;
        retire  = 1'b1;
        state_d = StFetch;
      end
      StHalt: begin
        if (go) state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase

    icount_d = retire ? icount_q + 16'd1 : icount_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StFetch;
      isr_q    <= 16'd0;
      icount_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      isr_q    <= isr_d;
      icount_q <= icount_d;
    end
  end

  assign isr    = isr_q;
  assign icount = icount_q;
  assign halted = (state_q == StHalt);

endmodule

// File: tb/tb_cpu_ctrl.sv
// Randomized scoreboard bench for cpu_ctrl: stimulus pushes the expected per-cycle outputs,
// a negedge monitor pops and compares them.
module tb_cpu_ctrl;

  logic        clk, reset, ivalid, go;
  logic [15:0] instr, isr, icount;
  logic        regw, memw, sflag, spld, pcin, pci, pcld, halted;
  logic [1:0]  memin, spi;

  cpu_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .instr  (instr),
    .ivalid (ivalid),
    .go     (go),
    .isr    (isr),
    .regw   (regw),
    .memw   (memw),
    .memin  (memin),
    .sflag  (sflag),
    .spi    (spi),
    .spld   (spld),
    .pcin   (pcin),
    .pci    (pci),
    .pcld   (pcld),
    .halted (halted),
    .icount (icount)
  );

  typedef struct packed {
    logic        regw;
    logic        memw;
    logic [1:0]  memin;
    logic        sflag;
    logic [1:0]  spi;
    logic        spld;
    logic        pcin;
    logic        pci;
    logic        pcld;
    logic        halted;
    logic [15:0] isr;
    logic [15:0] icount;
  } obs_t;

  obs_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [15:0] m_isr;
  logic [15:0] m_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input logic rw, input logic mw, input logic [1:0] mi,
                              input logic sf, input logic [1:0] si, input logic sl,
                              input logic pin, input logic pi, input logic pl,
                              input logic h);
    obs_t o;
    o.regw = rw; o.memw = mw; o.memin = mi; o.sflag = sf; o.spi = si; o.spld = sl;
    o.pcin = pin; o.pci = pi; o.pcld = pl; o.halted = h;
    o.isr = m_isr; o.icount = m_cnt;
    return o;
  endfunction

  function automatic obs_t idle();
    return mk(0, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0, 0);
  endfunction

  // Monitor: compare the observed outputs against the next expected entry.
  always @(negedge clk) begin
    obs_t g, e;
    cyc++;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g.regw = regw; g.memw = memw; g.memin = memin; g.sflag = sflag; g.spi = spi;
      g.spld = spld; g.pcin = pcin; g.pci = pci; g.pcld = pcld; g.halted = halted;
      g.isr = isr; g.icount = icount;
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL outputs cycle %0d: got rw=%b mw=%b mi=%0d sf=%b spi=%0d sl=%b pcin=%b pci=%b pcld=%b h=%b isr=%h ic=%0d; required rw=%b mw=%b mi=%0d sf=%b spi=%0d sl=%b pcin=%b pci=%b pcld=%b h=%b isr=%h ic=%0d",
                 cyc, g.regw, g.memw, g.memin, g.sflag, g.spi, g.spld, g.pcin, g.pci, g.pcld,
                 g.halted, g.isr, g.icount, e.regw, e.memw, e.memin, e.sflag, e.spi, e.spld,
                 e.pcin, e.pci, e.pcld, e.halted, e.isr, e.icount);
      end
    end
  end

  task automatic cycle(input obs_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    ivalid = 1'($urandom);
    instr  = 16'($urandom);
    go     = 1'($urandom);
  endtask

  // Issue one instruction; abort_step >= 0 asserts reset during that post-fetch step.
  task automatic run_instr(input logic [15:0] w, input int stalls, input int halt_cycles,
                           input int abort_step);
    obs_t steps[$];
    logic is_halt;
    for (int i = 0; i < stalls; i++) begin
      ivalid = 1'b0; instr = 16'($urandom); go = 1'($urandom);
      cycle(idle());
    end
    ivalid = 1'b1; instr = w; go = 1'($urandom);
    cycle(idle());
    m_isr = w;
    is_halt = 1'b0;
    if (w[15:12] <= 4'd8) begin
      steps.push_back(mk(0, 0, 2'd0, 0, 2'd0, 0, 1, 1, 1, 0));
    end else if (w[15:12] == 4'd9) begin
      steps.push_back(mk(0, 1, 2'd0, 0, 2'd2, 1, 1, 0, 1, 0));
    end else if (w[15:12] == 4'd10) begin
      steps.push_back(mk(0, 1, 2'd1, 0, 2'd2, 1, 0, 0, 0, 0));
      steps.push_back(mk(0, 0, 2'd0, 0, 2'd0, 0, 1, 1, 1, 0));
    end else if (w[15:12] == 4'd11) begin
      if (w[1:0] == 2'b00) begin
        steps.push_back(mk(0, 0, 2'd0, 0, 2'd1, 1, 0, 0, 0, 0));
        steps.push_back(mk(0, 0, 2'd0, 0, 2'd0, 0, 0, 0, 1, 0));
        steps.push_back(mk(0, 0, 2'd0, 0, 2'd0, 0, 1, 0, 1, 0));
      end else begin
        steps.push_back(mk(0, 0, 2'd0, 0, 2'd0, 0, 1, 0, 1, 0));
        is_halt = (w[1:0] == 2'b10);
      end
    end else begin
      steps.push_back(mk(1, 0, 2'd0, 1, 2'd0, 0, 1, 0, 1, 0));
    end
    for (int i = 0; i < steps.size(); i++) begin
      noise();
      if (i == abort_step) begin
        m_isr = 16'd0;
        m_cnt = 16'd0;
        exp_q.push_back(idle());
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        cycle(idle());
        reset = 1'b0;
        return;
      end
      cycle(steps[i]);
    end
    m_cnt = m_cnt + 16'd1;
    if (is_halt) begin
      for (int i = 0; i < halt_cycles; i++) begin
        ivalid = 1'($urandom); instr = 16'($urandom);
        go = (i == halt_cycles - 1);
        cycle(mk(0, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0, 1));
      end
    end
  endtask

  initial begin
    logic [15:0] w;
    reset = 1'b1; ivalid = 1'b1; instr = 16'hC800; go = 1'b0;
    m_isr = 16'd0; m_cnt = 16'd0;
    @(posedge clk);
    #1;
    cycle(idle());
    cycle(idle());
    reset = 1'b0;

    run_instr(16'hC800, 0, 0, -1);
    run_instr(16'h0FFE, 0, 0, -1);
    run_instr(16'hA010, 0, 0, -1);
    run_instr(16'hB000, 0, 0, -1);
    run_instr(16'hD123, 5, 0, -1);
    run_instr(16'hB002, 0, 11, -1);
    run_instr(16'hB002, 1, 1, -1);
    run_instr(16'h9300, 0, 0, -1);
    run_instr(16'hB001, 0, 0, -1);
    run_instr(16'hA010, 0, 0, -1);
    run_instr(16'hB000, 0, 0, 1);
    run_instr(16'hC800, 0, 0, -1);

    for (int n = 0; n < 300; n++) begin
      w = 16'($urandom);
      run_instr(w, $urandom_range(0, 3), $urandom_range(1, 4), -1);
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Multi-cycle sequencing controller for the 16-bit accumulator/stack datapath. It fetches instruction words from the instruction ROM and holds them in the instruction register that drives the datapath `isr` bus. It then decodes each word into per-cycle strobes: register write, memory write, flag update, stack-pointer and PC control. It sits beside the datapath, between the instruction ROM (addressed by the datapath `pcout`) and the datapath control inputs. The datapath PC and SP load enables are wired to this block's `pcld`/`spld` rather than tied high.

## Interface
- No parameters; widths fixed at 16-bit word, 16-bit retire counter.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: asynchronous, active-high.
- `instr` in 16: instruction word from ROM at current PC.
- `ivalid` in 1: `instr` is valid this cycle.
- `go` in 1: restart request; only observed in HALT.
- `isr` out 16: instruction register, drives datapath `isr`.
- `regw` out 1: register-bank write.
- `memw` out 1: data-memory write at address SP.
- `memin` out 2: memory write source; 0 = reg x, 1 = pc, 2 = sign-extended imm.
- `sflag` out 1: status flag register update.
- `spi` out 2: SP next value; 0 = hold, 1 = sp+1, 2 = sp-1.
- `spld` out 1: SP load enable.
- `pcin` out 1: PC source; 0 = memory out y, 1 = increment/branch path.
- `pci` out 1: 0 = pc+1; 1 = pc+1+simm12 if cc, else pc+1.
- `pcld` out 1: PC load enable.
- `halted` out 1: high in HALT state.
- `icount` out 16: retired-instruction count.

## Operation
- Decode uses `isr[15:12]` (op).
- op 0000–1000 = BR: the condition is computed by the datapath from the same bits.
  - EXEC drives pcin=1, pci=1, pcld=1.
- op 1001 = PUSH r(isr[10:8]).
  - EXEC drives memw=1, memin=0, spi=2, spld=1, pcin=1, pci=0, pcld=1.
  - Post-decrement push: write at old SP.
- op 1010 = CALL simm12.
  - EXEC drives memw=1, memin=1, spi=2, spld=1; pcld=0.
  - CALL2 drives pcin=1, pci=1, pcld=1. Op 1010 always yields cc=1 in the datapath.
- op 1011 = MISC, subop `isr[1:0]`:
  - 00 = RET.
  - 10 = HALT.
  - 01/11 = NOP (pc+1).
- RET sequence:
  - EXEC: spi=1, spld=1.
  - RET2: pcin=0, pcld=1; PC loads mem[SP].
  - RET3: pcin=1, pci=0, pcld=1; skips past the CALL.
- op 11xx = ALU: funsel = `isr[13:11]`.
  - EXEC drives regw=1, sflag=1, pcin=1, pci=0, pcld=1.
- States: FETCH, EXEC, CALL2, RET2, RET3, HALT. Transitions:
  - FETCH → EXEC when ivalid=1. `isr` loads `instr` on the same edge; otherwise stay in FETCH.
  - EXEC → CALL2 for CALL; → RET2 for RET; → HALT for MISC/10 (pc+1 asserted in EXEC); → FETCH otherwise.
  - CALL2 → FETCH.
  - RET2 → RET3 → FETCH.
  - HALT → FETCH when go=1.
- Strobe defaults: all strobes (regw, memw, sflag, spld, pcld) are 0 in FETCH, HALT and any state not listed above. Multi-bit controls default to 0.
- `icount` increments by 1, wrapping at 16'hFFFF → 0, on the final cycle of each instruction:
  - EXEC for single-cycle ops;
  - CALL2 for CALL;
  - RET3 for RET;
  - EXEC for HALT and NOP.

## Timing
- `isr`, state and `icount` are registered.
- All strobes are combinational from state and `isr` only, never from `instr`. Strobes are stable for the whole cycle; the datapath commits on the next rising edge.
- Latency, FETCH included:
  - BR/PUSH/ALU/NOP/HALT: 2 cycles.
  - CALL: 3 cycles.
  - RET: 4 cycles.
- FETCH with ivalid=0 waits indefinitely:
  - `isr` holds;
  - no strobes;
  - `icount` holds.
- `go` held high while not in HALT has no effect. go already high on HALT entry → leave HALT after exactly one HALT cycle.
- Reset values, applied asynchronously while reset is high:
  - state = FETCH;
  - `isr` = 0, `icount` = 0, `halted` = 0;
  - all strobes 0.
- Reset mid-instruction (e.g. in RET2) aborts with no further strobes. The datapath's own reset restores PC/SP.
- memw and pcld never both assert with pcin=0.
- memw is asserted only in EXEC of PUSH/CALL.

## Test plan
- Reset with instr=16'hC800 (ALU, funsel 1, r0), ivalid=1:
  - cycle 1: FETCH, no strobes;
  - cycle 2: regw=1, sflag=1, pcld=1, pcin=1, pci=0;
  - `icount`=1 after.
- BR sequence: instr=16'h0FFE (BR always, offset -2):
  - EXEC drives pcin=1, pci=1, pcld=1;
  - regw=0, memw=0.
- CALL followed by RET:
  - 16'hA010 drives, in order: memw=1, memin=1, spi=2, spld=1; then pci=1, pcld=1 in CALL2;
  - 16'hB000 drives, in order: spi=1/spld=1, pcin=0/pcld=1, pcin=1/pci=0/pcld=1;
  - `icount` +2 total.
- FETCH stall: ivalid low for 5 cycles:
  - state and `isr` hold, all strobes 0;
  - ivalid high → EXEC next cycle.
- HALT 16'hB002:
  - EXEC asserts pcld (pc+1), then `halted`=1 with strobes 0 for 10 cycles;
  - go=1 → FETCH next cycle, `halted`=0.
- Async reset asserted during RET2:
  - outputs drop to reset values before the next edge;
  - after release, first cycle is FETCH with `icount`=0.
